// File: rtl/bullet_pkg.sv
// Shared definitions for the player-bullet sequencer: FSM state encodings,
// default sprite dimensions and default frame-timing constants.
package bullet_pkg;

  // 3-bit Moore state encoding for the bullet FSM.
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_IDLE   = 3'd1,
    S_DRAW   = 3'd2,
    S_WAIT   = 3'd3,
    S_ERASE  = 3'd4,
    S_UPDATE = 3'd5,
    S_CHECK  = 3'd6
  } state_t;

  // Default sprite size in pixels (each 1..4).
  localparam int DEF_SPR_W = 2;
  localparam int DEF_SPR_H = 4;

  // Default frame timing: 50 MHz / 60 Hz, bullet held two frames per step.
  localparam int DEF_FRAME_TICKS = 833333;
  localparam int DEF_STEP_FRAMES = 2;

  // Width of the sprite pixel offsets (covers sprites up to 4x4).
  localparam int PIX_W = 2;

  // Counter width for a count of n states; never returns zero.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bullet_controller_frame_timer.sv
// frame_timer: counts FRAME_TICKS*STEP_FRAMES enabled cycles and pulses done
// on the last one. A tick counter runs inside a frame counter; both restart
// on clr, which has priority over en.
module frame_timer
  import bullet_pkg::*;
#(
  parameter int FRAME_TICKS = DEF_FRAME_TICKS,
  parameter int STEP_FRAMES = DEF_STEP_FRAMES
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int TICK_W  = cntWidth(FRAME_TICKS);
  localparam int FRAME_W = $clog2(STEP_FRAMES) + 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(FRAME_TICKS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(STEP_FRAMES - 1);

  logic [TICK_W-1:0]  tickCnt;
  logic [FRAME_W-1:0] frameCnt;
  logic               tickLast;
  logic               frameLast;

  assign tickLast  = (tickCnt == TICK_LAST);
  assign frameLast = (frameCnt == FRAME_LAST);
  assign done      = en & tickLast & frameLast;

  // Tick and frame counters; terminal counts compare for equality and restart.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tickCnt  <= '0;
      frameCnt <= '0;
    end else if (clr) begin
      tickCnt  <= '0;
      frameCnt <= '0;
    end else if (en) begin
      if (tickLast) begin
        tickCnt  <= '0;
        frameCnt <= frameLast ? '0 : frameCnt + 1'b1;
      end else begin
        tickCnt <= tickCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bullet_controller.sv
// bullet_controller: Moore FSM sequencing one player bullet through
// draw / hold / erase / advance steps until the datapath reports the top.
// Plot pixels are requested from the shared VGA port via plot_req/plot_gnt;
// the sprite pixel counter only advances on granted cycles.
// Build option: define BULLET_AUTOFIRE_EN to leave S_IDLE on the fire level
// instead of its rising edge, so a held button refires.
module bullet_controller
  import bullet_pkg::*;
#(
  parameter int SPR_W       = DEF_SPR_W,
  parameter int SPR_H       = DEF_SPR_H,
  parameter int FRAME_TICKS = DEF_FRAME_TICKS,
  parameter int STEP_FRAMES = DEF_STEP_FRAMES
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             fire,
  input  logic             top_reached,
  input  logic             plot_gnt,
  output logic             ld_reset,
  output logic             ld_update,
  output logic             ld_wait,
  output logic             plot_req,
  output logic             plot,
  output logic             erase,
  output logic [PIX_W-1:0] pix_dx,
  output logic [PIX_W-1:0] pix_dy,
  output logic             busy
);

  localparam logic [PIX_W-1:0] DX_LAST = PIX_W'(SPR_W - 1);
  localparam logic [PIX_W-1:0] DY_LAST = PIX_W'(SPR_H - 1);

  state_t           state;
  state_t           stateNext;
  logic             fireQ;
  logic             fireStart;
  logic [PIX_W-1:0] dxCnt;
  logic [PIX_W-1:0] dyCnt;
  logic             plotting;
  logic             pixStep;
  logic             lastPixel;
  logic             timerDone;

  assign plotting  = (state == S_DRAW) || (state == S_ERASE);
  assign pixStep   = plotting & plot_gnt;
  assign lastPixel = (dxCnt == DX_LAST) && (dyCnt == DY_LAST);

`ifdef BULLET_AUTOFIRE_EN
  assign fireStart = fire;
`else
  assign fireStart = fire & ~fireQ;
`endif

  frame_timer #(
    .FRAME_TICKS(FRAME_TICKS),
    .STEP_FRAMES(STEP_FRAMES)
  ) u_frame_timer (
    .clk   (clk),
    .resetn(resetn),
    .clr   (state != S_WAIT),
    .en    (state == S_WAIT),
    .done  (timerDone)
  );

  // Fire edge register, updated every cycle so a held button does not re-fire.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) fireQ <= 1'b0;
    else         fireQ <= fire;
  end

  // Sprite pixel counter: dx fastest, dy slowest, advancing only on grants.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dxCnt <= '0;
      dyCnt <= '0;
    end else if (pixStep) begin
      if (dxCnt == DX_LAST) begin
        dxCnt <= '0;
        dyCnt <= (dyCnt == DY_LAST) ? '0 : dyCnt + 1'b1;
      end else begin
        dxCnt <= dxCnt + 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_RESET;
    else         state <= stateNext;
  end

  // Next-state logic.
  // NOTE: combinational blocks assign a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    stateNext = state;
    case (state)
      S_RESET:  stateNext = S_IDLE;
      S_IDLE:   if (fireStart) stateNext = S_DRAW;
      S_DRAW:   if (pixStep && lastPixel) stateNext = S_WAIT;
      S_WAIT:   if (timerDone) stateNext = S_ERASE;
      S_ERASE:  if (pixStep && lastPixel) stateNext = S_UPDATE;
      S_UPDATE: stateNext = S_CHECK;
      S_CHECK:  stateNext = top_reached ? S_RESET : S_DRAW;
      default:  stateNext = S_RESET;
    endcase
  end

  // Moore output decode; offsets read zero outside the plotting states.
  always_comb begin
    ld_reset  = (state == S_RESET) || (state == S_IDLE);
    ld_update = (state == S_UPDATE);
    ld_wait   = (state == S_WAIT);
    plot_req  = plotting;
    plot      = plotting & plot_gnt;
    erase     = (state == S_ERASE);
    busy      = !((state == S_RESET) || (state == S_IDLE));
    pix_dx    = plotting ? dxCnt : '0;
    pix_dy    = plotting ? dyCnt : '0;
  end

endmodule
